// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg
//  Shared definitions for the PC / instruction-fetch sequencer.
//  - fetch_state_t : fetch FSM states. FAULT is only reachable when the
//                    design is built with PC_BOUNDS_CHECK_EN.
//  - DEF_ADDR_W, DEF_RESET_PC : default PC width and reset vector.
//  - INSTR_W       : instruction word width.
package pc_fetch_pkg;

   localparam int          DEF_ADDR_W   = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'h0;
   localparam int          INSTR_W      = 32;

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      REQ   = 3'd1,
      WAIT  = 3'd2,
      HOLD  = 3'd3,
      FAULT = 3'd4
   } fetch_state_t;

endpackage

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl
//  Program-counter register and instruction-fetch sequencer. pc_out feeds an
//  external registered PC+1 adder whose result comes back on next_pc. Fetches
//  are word addressed and issued one at a time over a valid/ready request
//  channel; each accepted request returns exactly one in-order response pulse.
//  Fetched words go to decode with instr_valid, held while decode stalls.
//  Branch/jump redirects replace the PC and squash any in-flight fetch.
//
//  Build option: define PC_BOUNDS_CHECK_EN to add a range check on the PC.
//  Entering REQ with pc_out >= IMEM_DEPTH parks the FSM in FAULT (sticky
//  fault=1, no request) until a redirect to an in-range PC or reset. Without
//  the macro fault is tied low and no check exists.
//
//  Ports
//   clock, reset          rising-edge clock, async active-high reset
//   next_pc               registered pc_out+1 from the adder
//   redirect_valid/_pc    taken branch/jump pulse and target
//   stall                 decode not ready, hold the current instruction
//   pc_out                current PC
//   imem_req_valid/_addr  fetch request (addr = pc_out)
//   imem_req_ready        memory accepts request
//   imem_resp_valid/_data fetch response pulse and word
//   instr_valid/_out/_pc  instruction to decode and its PC
//   fault                 sticky bounds fault
module pc_fetch_ctrl
   import pc_fetch_pkg::*;
#(
   parameter int                ADDR_W     = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
   parameter int                IMEM_DEPTH = 256
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [ADDR_W-1:0]  next_pc,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               stall,
   output logic [ADDR_W-1:0]  pc_out,
   output logic               imem_req_valid,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_resp_valid,
   input  logic [INSTR_W-1:0] imem_resp_data,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr_out,
   output logic [ADDR_W-1:0]  instr_pc,
   output logic               fault
);

   fetch_state_t       state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               drop_q, drop_d;     // in-flight response must be discarded
   logic               ivld_q, ivld_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  ipc_q, ipc_d;
   logic               req_valid;

`ifdef PC_BOUNDS_CHECK_EN
   localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(IMEM_DEPTH);

   function automatic logic out_of_range(input logic [ADDR_W-1:0] pc);
      return {1'b0, pc} >= DEPTH_EXT;
   endfunction
`else
   logic unused_depth;
   assign unused_depth = ^IMEM_DEPTH;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      drop_d    = drop_q;
      ivld_d    = 1'b0;                     // instr_valid is a pulse unless held
      instr_d   = instr_q;
      ipc_d     = ipc_q;
      req_valid = 1'b0;

      case (state_q)
         // One idle cycle so the adder register sees the reset/redirect PC.
         BOOT: begin
            if (redirect_valid) pc_d = redirect_pc;
            state_d = REQ;
         end

         REQ: begin
            req_valid = 1'b1;
            if (redirect_valid) begin
               pc_d = redirect_pc;
               // Old address was accepted this edge: its response is stale.
               if (imem_req_ready) begin
                  state_d = WAIT;
                  drop_d  = 1'b1;
               end
            end else if (imem_req_ready) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (redirect_valid) begin
               pc_d = redirect_pc;
               if (imem_resp_valid) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  drop_d  = 1'b1;
               end
            end else if (imem_resp_valid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  ivld_d  = 1'b1;
                  instr_d = imem_resp_data;
                  ipc_d   = pc_q;
                  if (stall) begin
                     state_d = HOLD;
                  end else begin
                     pc_d    = next_pc;
                     state_d = REQ;
                  end
               end
            end
         end

         HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = REQ;
            end else if (stall) begin
               ivld_d  = 1'b1;
            end else begin
               pc_d    = next_pc;
               state_d = REQ;
            end
         end

`ifdef PC_BOUNDS_CHECK_EN
         FAULT: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = REQ;
            end
         end
`endif

         default: state_d = BOOT;
      endcase

`ifdef PC_BOUNDS_CHECK_EN
      // Every path into REQ passes here, so REQ never holds an illegal PC.
      if (state_d == REQ && out_of_range(pc_d)) state_d = FAULT;
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         drop_q  <= 1'b0;
         ivld_q  <= 1'b0;
         instr_q <= '0;
         ipc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         ivld_q  <= ivld_d;
         instr_q <= instr_d;
         ipc_q   <= ipc_d;
      end
   end

   assign pc_out         = pc_q;
   assign imem_req_valid = req_valid;
   assign imem_req_addr  = pc_q;
   assign instr_valid    = ivld_q;
   assign instr_out      = instr_q;
   assign instr_pc       = ipc_q;

`ifdef PC_BOUNDS_CHECK_EN
   assign fault = (state_q == FAULT);
`else
   assign fault = 1'b0;
`endif

endmodule
